// File: rtl/bus_arbiter.sv
// Registered shared-bus arbiter: fixed-priority or round-robin winner selection with
// owner lock hold, contention flag and saturating contention counter.
module bus_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_SRC  = 5,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_SRC-1:0]        req_i,
  input  logic [N_SRC-1:0]        lock_i,
  input  logic [N_SRC*DATA_W-1:0] data_i,
  input  logic                    clr_cnt_i,
  output logic [DATA_W-1:0]       bus_o,
  output logic                    bus_valid_o,
  output logic [N_SRC-1:0]        grant_o,
  output logic                    contention_o,
  output logic [CNT_W-1:0]        contention_cnt_o
);

  localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  own_idx, win_idx;
  logic              win_valid, hold, contended;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic              valid_q;
  logic              cont_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant_q[i]) own_idx = PTR_W'(i);
    end
  end

  // grant_q is one-hot, so this is set only when the current owner still requests and locks.
  assign hold = |(grant_q & req_i & lock_i);

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    if (hold) begin
      win_valid = 1'b1;
      win_idx   = own_idx;
    end else if (MODE == 0) begin
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          win_valid = 1'b1;
          win_idx   = PTR_W'(i);
        end
      end
    end else begin
      // Descending scan so the last hit is the first set bit at or after ptr_q.
      for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
        if (req_i[(int'(ptr_q) + k) % int'(N_SRC)]) begin
          win_valid = 1'b1;
          win_idx   = PTR_W'((int'(ptr_q) + k) % int'(N_SRC));
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign contended = |(req_i & (req_i - N_SRC'(1)));

  always_comb begin
    grant_d = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      grant_d[i] = win_valid && (win_idx == PTR_W'(i));
    end
  end

  always_comb begin
    bus_d = '0;
    if (win_valid) bus_d = data_i[int'(win_idx)*DATA_W +: DATA_W];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win_valid) begin
      ptr_d = (win_idx == PTR_W'(N_SRC - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (contended && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      bus_q   <= bus_d;
      valid_q <= win_valid;
      cont_q  <= contended;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o          = grant_q;
  assign bus_o            = bus_q;
  assign bus_valid_o      = valid_q;
  assign contention_o     = cont_q;
  assign contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (fixed priority, round-robin, 2-bit counter) share
// one directed stimulus and are checked every cycle against an integer-level model.
module tb_bus_arbiter;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic [4:0]   req;
  logic [4:0]   lock;
  logic         clr;
  logic [39:0]  data;

  logic [7:0]   bus   [3];
  logic         valid [3];
  logic [4:0]   grant [3];
  logic         cont  [3];
  logic [7:0]   cnt0, cnt1;
  logic [1:0]   cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_arbiter #(.DATA_W(8), .N_SRC(5), .MODE(0), .CNT_W(8)) u_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .data_i(data), .clr_cnt_i(clr),
    .bus_o(bus[0]), .bus_valid_o(valid[0]), .grant_o(grant[0]), .contention_o(cont[0]),
    .contention_cnt_o(cnt0)
  );

  bus_arbiter #(.DATA_W(8), .N_SRC(5), .MODE(1), .CNT_W(8)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .data_i(data), .clr_cnt_i(clr),
    .bus_o(bus[1]), .bus_valid_o(valid[1]), .grant_o(grant[1]), .contention_o(cont[1]),
    .contention_cnt_o(cnt1)
  );

  bus_arbiter #(.DATA_W(8), .N_SRC(5), .MODE(0), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .data_i(data), .clr_cnt_i(clr),
    .bus_o(bus[2]), .bus_valid_o(valid[2]), .grant_o(grant[2]), .contention_o(cont[2]),
    .contention_cnt_o(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic int mode_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int cmax(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    if (i == 0) return 32'(cnt0);
    if (i == 1) return 32'(cnt1);
    return 32'(cnt2);
  endfunction

  // Model: owner is the granted source index, -1 when idle; data of source k is 8'h10+k.
  int m_owner [3] = '{-1, -1, -1};
  int m_ptr   [3] = '{0, 0, 0};
  int m_cnt   [3] = '{0, 0, 0};
  int m_cont  [3] = '{0, 0, 0};
  int m_bus   [3] = '{0, 0, 0};
  int w, nreq, jj;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_owner[i] = -1; m_ptr[i] = 0; m_cnt[i] = 0; m_cont[i] = 0; m_bus[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        nreq = $countones(req);
        w = -1;
        if (m_owner[i] >= 0 && req[m_owner[i]] && lock[m_owner[i]]) begin
          w = m_owner[i];
        end else if (mode_of(i) == 0) begin
          for (int k = 0; k < N; k++) if (w < 0 && req[k]) w = k;
        end else begin
          for (int k = 0; k < N; k++) begin
            jj = (m_ptr[i] + k) % N;
            if (w < 0 && req[jj]) w = jj;
          end
        end
        m_owner[i] = w;
        if (w >= 0) begin
          m_ptr[i] = (w + 1) % N;
          m_bus[i] = 16 + w;
        end else begin
          m_bus[i] = 0;
        end
        m_cont[i] = (nreq >= 2) ? 1 : 0;
        if (clr) m_cnt[i] = 0;
        else if (nreq >= 2 && m_cnt[i] < cmax(i)) m_cnt[i]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("model_grant", i, 32'(grant[i]), (m_owner[i] >= 0) ? (32'd1 << m_owner[i]) : 32'd0);
      check("model_bus",   i, 32'(bus[i]),   32'(m_bus[i]));
      check("model_valid", i, 32'(valid[i]), (m_owner[i] >= 0) ? 32'd1 : 32'd0);
      check("model_cont",  i, 32'(cont[i]),  32'(m_cont[i]));
      check("model_cnt",   i, cnt_of(i),     32'(m_cnt[i]));
    end
  end

  task automatic drive(input logic [4:0] r, input logic [4:0] l, input logic c);
    req  = r;
    lock = l;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rr_exp [6];
  logic [4:0] tbl_req  [8];
  logic [4:0] tbl_lock [8];

  initial begin
    rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    tbl_req  = '{5'b10100, 5'b10100, 5'b10100, 5'b00110, 5'b11000, 5'b11000, 5'b00011, 5'b10001};
    tbl_lock = '{5'b00000, 5'b10100, 5'b10100, 5'b00100, 5'b11111, 5'b01000, 5'b00000, 5'b10001};
    data = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    req = '0; lock = '0; clr = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #11;
    for (int i = 0; i < 3; i++) begin
      check("rst_grant", i, 32'(grant[i]), 32'd0);
      check("rst_bus",   i, 32'(bus[i]),   32'd0);
      check("rst_valid", i, 32'(valid[i]), 32'd0);
      check("rst_cnt",   i, cnt_of(i),     32'd0);
    end
    #11 rst = 1'b0;

    // All five request: round-robin rotates, fixed priority stays on source 0.
    for (int s = 0; s < 6; s++) begin
      drive(5'b11111, 5'b00000, 1'b0);
      check("rr_grant", 1, 32'(grant[1]), 32'(rr_exp[s]));
      check("rr_bus",   1, 32'(bus[1]),   32'h10 + 32'(s % 5));
      check("fp_grant", 0, 32'(grant[0]), 32'd1);
    end
    check("rr_cnt",  1, cnt_of(1), 32'd6);
    check("sat_cnt", 2, cnt_of(2), 32'd3);

    drive(5'b10110, 5'b00000, 1'b1);
    check("clr_cnt",  0, cnt_of(0), 32'd0);
    check("clr_cnt",  2, cnt_of(2), 32'd0);
    drive(5'b10110, 5'b00000, 1'b0);
    check("fp_grant", 0, 32'(grant[0]), 32'b00010);
    check("fp_bus",   0, 32'(bus[0]),   32'h11);
    check("fp_valid", 0, 32'(valid[0]), 32'd1);
    check("fp_cont",  0, 32'(cont[0]),  32'd1);
    check("fp_cnt",   0, cnt_of(0),     32'd1);

    drive(5'b01000, 5'b01000, 1'b0);
    check("lock_grant", 0, 32'(grant[0]), 32'b01000);
    for (int s = 0; s < 3; s++) begin
      drive(5'b01001, 5'b01000, 1'b0);
      check("lock_hold", 0, 32'(grant[0]), 32'b01000);
      check("lock_bus",  0, 32'(bus[0]),   32'h13);
    end
    drive(5'b01001, 5'b00000, 1'b0);
    check("unlock_grant", 0, 32'(grant[0]), 32'b00001);
    check("unlock_bus",   0, 32'(bus[0]),   32'h10);

    drive(5'b00000, 5'b00000, 1'b0);
    check("idle_grant", 0, 32'(grant[0]), 32'd0);
    check("idle_bus",   0, 32'(bus[0]),   32'd0);
    check("idle_valid", 0, 32'(valid[0]), 32'd0);
    check("idle_cont",  0, 32'(cont[0]),  32'd0);

    // Reset between edges while source 2 holds a lock.
    drive(5'b00100, 5'b00100, 1'b0);
    drive(5'b00100, 5'b00100, 1'b0);
    check("pre_rst_grant", 1, 32'(grant[1]), 32'b00100);
    req = 5'b11111; lock = 5'b00000;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_rst_grant", i, 32'(grant[i]), 32'd0);
      check("async_rst_bus",   i, 32'(bus[i]),   32'd0);
      check("async_rst_valid", i, 32'(valid[i]), 32'd0);
      check("async_rst_cnt",   i, cnt_of(i),     32'd0);
    end
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rr", 1, 32'(grant[1]), 32'b00001);
    check("post_rst_fp", 0, 32'(grant[0]), 32'b00001);

    for (int s = 0; s < 8; s++) drive(tbl_req[s], tbl_lock[s], 1'b0);
    drive(5'b00000, 5'b00000, 1'b0);
    drive(5'b00000, 5'b00000, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
